// File: rtl/signed_vedic_mult_pipe_pkg.sv
// Shared constants and helpers for the signed Vedic multiplier pipeline.
// The optional SVM_ACC_EN build uses SVM_ACC_GUARD as the accumulator headroom.
package svm_pkg;

  localparam int SVM_LATENCY   = 3;
  localparam int SVM_ACC_GUARD = 8;

  // Quadrant width: operands are split into two halves of this size.
  function automatic int svm_half(input int width);
    return (width + 1) / 2;
  endfunction

endpackage

// File: rtl/signed_vedic_mult_pipe_vedic_umul.sv
// Purely combinational unsigned N x N multiplier, built by recursively splitting
// the operands into quadrants down to Vedic 2x2 cells.
module vedic_umul #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  if (N == 1) begin : g_bit
    assign p = {1'b0, a[0] & b[0]};
  end else if (N == 2) begin : g_cell
    // Vertical-and-crosswise 2x2 cell: cross products sum into the middle column.
    logic [1:0] mid;
    logic [1:0] top;
    assign mid = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
    assign top = {1'b0, a[1] & b[1]} + {1'b0, mid[1]};
    assign p   = {top, mid[0], a[0] & b[0]};
  end else begin : g_split
    localparam int H = (N + 1) / 2;
    logic [2*H-1:0] a_ext, b_ext;
    logic [2*H-1:0] p_ll, p_hl, p_lh, p_hh;
    logic [4*H-1:0] p_full;

    assign a_ext = (2*H)'(a);
    assign b_ext = (2*H)'(b);

    vedic_umul #(.N(H)) u_ll (.a(a_ext[H-1:0]),   .b(b_ext[H-1:0]),   .p(p_ll));
    vedic_umul #(.N(H)) u_hl (.a(a_ext[2*H-1:H]), .b(b_ext[H-1:0]),   .p(p_hl));
    vedic_umul #(.N(H)) u_lh (.a(a_ext[H-1:0]),   .b(b_ext[2*H-1:H]), .p(p_lh));
    vedic_umul #(.N(H)) u_hh (.a(a_ext[2*H-1:H]), .b(b_ext[2*H-1:H]), .p(p_hh));

    assign p_full = (4*H)'(p_ll)
                  + (((4*H)'(p_hl) + (4*H)'(p_lh)) << H)
                  + ((4*H)'(p_hh) << (2*H));
    assign p = p_full[2*N-1:0];

    // Odd N pads with zeros, so the bits above 2*N are always zero.
    if (4*H > 2*N) begin : g_trunc
      logic p_unused;
      assign p_unused = ^p_full[4*H-1:2*N];
    end
  end

endmodule

// File: rtl/signed_vedic_mult_pipe.sv
// Three-stage signed multiplier (magnitude, quadrant products, combine/sign).
// Defining SVM_ACC_EN turns the last stage into a multiply-accumulate with acc_clr.
module signed_vedic_mult_pipe
  import svm_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int HALF  = svm_half(WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_a,
  input  logic [WIDTH-1:0]                 in_b,
  output logic                             out_valid,
  input  logic                             out_ready,
`ifdef SVM_ACC_EN
  input  logic                             acc_clr,
  output logic [2*WIDTH+SVM_ACC_GUARD-1:0] out_p
`else
  output logic [2*WIDTH-1:0]               out_p
`endif
);

  // Handshake: a beat moves on a port when its valid and ready are both high
  // at a rising edge; all stages shift together whenever the output slot frees.
  logic adv, take;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~rst;
  assign take     = in_valid & in_ready;

  // Stage 1: magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_in;
  assign mag_a  = in_a[WIDTH-1] ? (~in_a + WIDTH'(1)) : in_a;
  assign mag_b  = in_b[WIDTH-1] ? (~in_b + WIDTH'(1)) : in_b;
  assign neg_in = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (|in_a) & (|in_b);

  logic             s1_valid, s1_neg;
  logic [WIDTH-1:0] s1_mag_a, s1_mag_b;

  // Stage 2: four quadrant products of the zero-extended magnitudes.
  logic [2*HALF-1:0] ext_a, ext_b;
  logic [2*HALF-1:0] q_ll, q_hl, q_lh, q_hh;
  assign ext_a = (2*HALF)'(s1_mag_a);
  assign ext_b = (2*HALF)'(s1_mag_b);

  vedic_umul #(.N(HALF)) u_ll (.a(ext_a[HALF-1:0]),      .b(ext_b[HALF-1:0]),      .p(q_ll));
  vedic_umul #(.N(HALF)) u_hl (.a(ext_a[2*HALF-1:HALF]), .b(ext_b[HALF-1:0]),      .p(q_hl));
  vedic_umul #(.N(HALF)) u_lh (.a(ext_a[HALF-1:0]),      .b(ext_b[2*HALF-1:HALF]), .p(q_lh));
  vedic_umul #(.N(HALF)) u_hh (.a(ext_a[2*HALF-1:HALF]), .b(ext_b[2*HALF-1:HALF]), .p(q_hh));

  logic              s2_valid, s2_neg;
  logic [2*HALF-1:0] s2_ll, s2_hl, s2_lh, s2_hh;

`ifdef SVM_ACC_EN
  logic s1_clr, s2_clr;
`endif

  // Stage 3: recombine quadrants; |p| <= 2^(2*WIDTH-2) so truncation is exact.
  logic [4*HALF-1:0]  u_full;
  logic [2*WIDTH-1:0] u, prod;
  assign u_full = (4*HALF)'(s2_ll)
                + (((4*HALF)'(s2_hl) + (4*HALF)'(s2_lh)) << HALF)
                + ((4*HALF)'(s2_hh) << (2*HALF));
  assign u      = u_full[2*WIDTH-1:0];
  assign prod   = s2_neg ? (~u + (2*WIDTH)'(1)) : u;

  if (4*HALF > 2*WIDTH) begin : g_trunc
    logic u_unused;
    assign u_unused = ^u_full[4*HALF-1:2*WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_neg    <= 1'b0;
      s1_mag_a  <= '0;
      s1_mag_b  <= '0;
      s2_valid  <= 1'b0;
      s2_neg    <= 1'b0;
      s2_ll     <= '0;
      s2_hl     <= '0;
      s2_lh     <= '0;
      s2_hh     <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
`ifdef SVM_ACC_EN
      s1_clr    <= 1'b0;
      s2_clr    <= 1'b0;
`endif
    end else if (adv) begin
      s1_valid  <= take;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (take) begin
        s1_mag_a <= mag_a;
        s1_mag_b <= mag_b;
        s1_neg   <= neg_in;
`ifdef SVM_ACC_EN
        s1_clr   <= acc_clr;
`endif
      end
      if (s1_valid) begin
        s2_ll  <= q_ll;
        s2_hl  <= q_hl;
        s2_lh  <= q_lh;
        s2_hh  <= q_hh;
        s2_neg <= s1_neg;
`ifdef SVM_ACC_EN
        s2_clr <= s1_clr;
`endif
      end
      if (s2_valid) begin
`ifdef SVM_ACC_EN
        out_p <= (s2_clr ? '0 : out_p) + {{SVM_ACC_GUARD{prod[2*WIDTH-1]}}, prod};
`else
        out_p <= prod;
`endif
      end
    end
  end

endmodule

// File: tb/tb_signed_vedic_mult_pipe.sv
// Randomised bench for signed_vedic_mult_pipe: a transaction-level model fills
// an expected queue and a negedge scoreboard compares every output handshake.
module tb_signed_vedic_mult_pipe;
  import svm_pkg::*;

`ifdef SVM_ACC_EN
  localparam int W  = 8;
  localparam int PW = 2*W + SVM_ACC_GUARD;
`else
  localparam int W  = 9;
  localparam int PW = 2*W;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [PW-1:0] out_p;
`ifdef SVM_ACC_EN
  logic          acc_clr = 1'b0;
`endif

  int            errors = 0;
  int            checks = 0;
  logic [PW-1:0] exp_q[$];
  longint        model_acc = 0;

  signed_vedic_mult_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SVM_ACC_EN
    .acc_clr  (acc_clr),
`endif
    .out_p    (out_p)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void push_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic clr);
    longint pa;
    pa = longint'($signed(a)) * longint'($signed(b));
`ifdef SVM_ACC_EN
    model_acc = (clr ? 64'sd0 : model_acc) + pa;
    exp_q.push_back(PW'(model_acc));
`else
    if (clr) model_acc = 0;
    exp_q.push_back(PW'(pa));
`endif
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = {1'b1, {(W-1){1'b0}}};
      1:       v = '0;
      2:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got out_p=%0d with nothing expected", $signed(out_p));
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (out_p !== e) begin
          errors++;
          $display("FAIL sb_product: got %0d required %0d", $signed(out_p), $signed(e));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic clr, output logic took);
    in_valid = v;
    in_a     = a;
    in_b     = b;
`ifdef SVM_ACC_EN
    acc_clr  = clr;
`endif
    @(negedge clk);
    took = v && (in_ready === 1'b1);
    if (took) push_model(a, b, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    logic took;
    int   n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 50) begin
      drive(1'b0, '0, '0, 1'b0, took);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d out_valid=%b required 0/0", exp_q.size(), out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic took;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, rand_op(), rand_op(), 1'b0, took);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready: got %b required 0", in_ready);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || out_p !== '0) begin
      errors++;
      $display("FAIL reset_out: out_valid=%b out_p=%0h required 0/0", out_valid, out_p);
    end
    rst = 1'b0;
    model_acc = 0;
    exp_q.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_latency(input logic [W-1:0] a, input logic [W-1:0] b,
                              input longint exp_const);
    logic took;
    int   k;
    out_ready = 1'b1;
    drive(1'b1, a, b, 1'b0, took);
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL lat_accept: in_ready=%b required 1", in_ready);
    end
    k = 1;
    while (out_valid !== 1'b1 && k < 20) begin
      drive(1'b0, '0, '0, 1'b0, took);
      k++;
    end
    checks++;
    if (k != SVM_LATENCY) begin
      errors++;
      $display("FAIL latency: got %0d cycles required %0d", k, SVM_LATENCY);
    end
`ifndef SVM_ACC_EN
    checks++;
    if (out_p !== PW'(exp_const)) begin
      errors++;
      $display("FAIL directed_value: got %0d required %0d", $signed(out_p), exp_const);
    end
`else
    if (exp_const != 0) model_acc = model_acc;
`endif
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic took;
    int   refused = 0;
    int   gaps = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 + SVM_LATENCY - 1; i++) begin
      if (i < 100) begin
        drive(1'b1, rand_op(), rand_op(), ($urandom_range(0, 7) == 0), took);
        if (!took) refused++;
      end else begin
        drive(1'b0, '0, '0, 1'b0, took);
      end
      if (i + 1 >= SVM_LATENCY && out_valid !== 1'b1) gaps++;
    end
    checks++;
    if (refused != 0) begin
      errors++;
      $display("FAIL b2b_accept: refused=%0d required 0", refused);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL b2b_continuous: gaps=%0d required 0", gaps);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic          took;
    logic [PW-1:0] held;
    logic [W-1:0]  a4, b4;
    int            refused = 0;
    int            moved = 0;
    int            n = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_op(), rand_op(), ($urandom_range(0, 3) == 0), took);
      if (!took) refused++;
    end
    checks++;
    if (refused != 0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_fill: refused=%0d out_valid=%b required 0/1", refused, out_valid);
    end
    held = out_p;
    a4 = rand_op();
    b4 = rand_op();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, a4, b4, 1'b0, took);
      if (took || out_valid !== 1'b1 || out_p !== held) moved++;
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d stall cycles changed or accepted, required 0", moved);
    end
    out_ready = 1'b1;
    took = 1'b0;
    while (!took && n < 10) begin
      drive(1'b1, a4, b4, 1'b0, took);
      n++;
    end
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL bp_resume: pair not accepted after release, in_ready=%b", in_ready);
    end
    wait_drain();
  endtask

  task automatic test_reset_inflight();
    logic took;
    int   refused = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, rand_op(), rand_op(), 1'b0, took);
      if (!took) refused++;
    end
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, took);
    rst = 1'b0;
    exp_q.delete();
    model_acc = 0;
    checks++;
    if (refused != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstf_out_valid: got %b required 0 (refused=%0d)", out_valid, refused);
    end
    drive(1'b1, rand_op(), rand_op(), 1'b0, took);
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL rstf_accept: in_ready=%b required 1", in_ready);
    end
    wait_drain();
  endtask

`ifdef SVM_ACC_EN
  task automatic test_acc();
    logic   took;
    int     ta[3];
    int     tbv[3];
    logic   tc[3];
    longint te[3];
    ta  = '{3, -2, 7};
    tbv = '{4, 5, 7};
    tc  = '{1'b0, 1'b0, 1'b1};
    te  = '{12, 2, 49};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, W'(ta[i]), W'(tbv[i]), tc[i], took);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_p !== PW'(te[i])) begin
        errors++;
        $display("FAIL acc_seq[%0d]: got %0d valid=%b required %0d", i, $signed(out_p),
                 out_valid, te[i]);
      end
      drive(1'b0, '0, '0, 1'b0, took);
    end
    wait_drain();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
`ifdef SVM_ACC_EN
    test_acc();
`endif
    test_latency(W'(-256), W'(-256), 65536);
    test_latency(W'(-256), W'(255), -65280);
    test_latency(W'(-3), W'(5), -15);
    test_latency(W'(0), W'(-7), 0);
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/signed_vedic_mult_pipe.md
Name: signed_vedic_mult_pipe

Overview:
- Parametrised, pipelined signed (two's-complement) multiplier built on the Vedic quadrant decomposition.
- Successor to the fixed 9-bit combinational sign-magnitude multiplier:
  - generic WIDTH
  - exact result for every input pair, including the most-negative value
  - registered 3-stage pipeline with valid/ready flow control
- Sits between datapath producers and DSP consumers that need one product per clock.

Parameters:
- WIDTH, 9: operand width in bits, two's complement; legal range 4..32.
- HALF, (WIDTH+1)/2: quadrant width, derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts operands this cycle
- in_a  input  WIDTH  signed multiplicand
- in_b  input  WIDTH  signed multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product this cycle
- out_p  output  2*WIDTH  signed product
- acc_clr  input  1  accumulator clear; present only with SVM_ACC_EN

Behaviour:
- Reset: one clock and `rst`; reset is synchronous and active-high.
  - `rst` high at a rising edge clears all stage valid bits, out_valid=0, out_p=0 and data registers to 0.
  - Any in-flight operations are discarded with no output.
  - in_ready is 0 during reset cycles and 1 in the first cycle after.
- Pipeline advance: adv = ~out_valid | out_ready. All three stages advance together when adv=1 and hold otherwise.
  - in_ready = adv, combinational from out_valid/out_ready, with no path from in_valid.
  - Transfer occurs when in_valid & in_ready. Bubbles propagate as invalid slots and are not collapsed.
- Stage 1 (S1), magnitude capture:
  - mag_a = in_a[WIDTH-1] ? -in_a : in_a, zero-extended to WIDTH unsigned bits. Likewise mag_b.
  - Most-negative -2^(WIDTH-1) yields magnitude 2^(WIDTH-1), held without overflow in WIDTH unsigned bits.
  - neg = in_a[MSB] ^ in_b[MSB].
  - Forced neg=0 when either operand is zero, so no negative zero.
- Stage 2 (S2), quadrants:
  - Zero-extend magnitudes to 2*HALF bits and split into hi/lo halves.
  - Register four unsigned HALF x HALF products (ll, hl, lh, hh), each 2*HALF bits. Propagate neg.
- Stage 3 (S3), combine and sign:
  - u = ll + (hl+lh)<<HALF + hh<<(2*HALF), computed in 2*HALF*2 bits then truncated to 2*WIDTH bits. Truncation is lossless because |p| <= 2^(2*WIDTH-2).
  - out_p = neg ? -u : u, registered.
- Latency: an accepted pair appears on out_p exactly 3 cycles later when no stall occurs.
  - Throughput: 1 product per cycle.
  - out_p and out_valid are stable while out_valid & ~out_ready.
- Simultaneous events:
  - rst has priority over in_valid/out_ready.
  - A transfer in and out in the same cycle is legal; the pipeline stays full.

Optional Feature:
- Macro: SVM_ACC_EN.
- Defined:
  - Adds port acc_clr.
  - S3 becomes a multiply-accumulate: acc <= (acc_clr ? 0 : acc) + signed product on each valid S3 advance. acc is 2*WIDTH+8 bits, wraps modulo 2^(2*WIDTH+8).
  - out_p widens to 2*WIDTH+8 and presents the updated acc.
  - acc_clr is sampled with the operand pair (carried in S1/S2 alongside data), so clear applies to that product.
  - rst clears acc.
- Undefined: no accumulator, no acc_clr port, out_p is 2*WIDTH bits.

Decomposition:
- Package svm_pkg:
  - function svm_half(width) returning HALF
  - localparam SVM_LATENCY=3
  - localparam SVM_ACC_GUARD=8
- Sub-module vedic_umul #(N): purely combinational unsigned N x N multiplier using recursive Vedic 2x2 cells. Instantiated four times with N=HALF in S2.
- The top holds all registers and flow control.

Test Plan:
- WIDTH=9, a=-256, b=-256, out_ready=1 -> out_p=65536 (0x10000) exactly 3 cycles after accept. a=-256, b=255 -> -65280.
- a=-3, b=5 -> out_p=-15 (18'h3FFF1). a=0, b=-7 -> out_p=0, no negative zero.
- Back-to-back stream: 100 random pairs, one per cycle, out_ready=1 -> 100 products in order, each equal to a*b, out_valid continuous after 3-cycle fill.
- Backpressure: fill with 3 pairs, then out_ready=0 for 5 cycles -> in_ready=0 and out_p held stable. Release -> remaining products in order, none dropped or duplicated.
- rst asserted one cycle while 2 pairs are in flight -> out_valid=0 next cycle, neither product ever emitted; new pair accepted the cycle after rst deasserts.
- SVM_ACC_EN, WIDTH=8: pairs (3,4), (-2,5), then (7,7) with acc_clr=1 -> out_p sequence 12, 2, 49.
